// File: rtl/uart_rx_ctrl_if.sv
// Handshake between the UART receive controller and its sampler, shifter and
// start/parity/stop checker blocks.
interface uart_rx_ctrl_if #(
    parameter int unsigned PRESC_W = 6
);
    logic [PRESC_W-1:0] edge_count;
    logic [3:0]         bit_count;
    logic               samp_en;
    logic               deser_en;
    logic               strt_chk_en;
    logic               par_chk_en;
    logic               stp_chk_en;
    logic               strt_glitch;
    logic               par_err;
    logic               stp_err;

    modport master (
        output edge_count, bit_count, samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
        input  strt_glitch, par_err, stp_err
    );

    modport slave (
        input  edge_count, bit_count, samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
        output strt_glitch, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Frame-level UART receive controller: start detection, oversampling edge/bit
// counters, datapath enables and one-cycle per-frame result pulses.
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESC_W    = 6
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_rx_in,
    input  logic               i_par_en,
    input  logic [PRESC_W-1:0] i_prescale,
    uart_rx_ctrl_if.master     dp,
    output logic               o_data_valid,
    output logic               o_parity_error,
    output logic               o_framing_error,
    output logic               o_busy
);
    localparam int unsigned      BIT_W    = 4;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PRESC_W-1:0] r_edge, w_edge_nxt;
    logic [BIT_W-1:0]   r_bit, w_bit_nxt;
    logic               r_par_flag, w_par_flag_nxt;
    logic               r_stp_flag, w_stp_flag_nxt;
    logic [4:0]         r_en, w_en_nxt;        // {samp, deser, strt_chk, par_chk, stp_chk}
    logic [2:0]         r_pulse, w_pulse_nxt;  // {data_valid, parity_error, framing_error}
    logic [PRESC_W-1:0] w_chk, w_last;
    logic               w_at_chk, w_at_last;

    assign w_chk     = (i_prescale >> 1) + PRESC_W'(2);
    assign w_last    = i_prescale - PRESC_W'(1);
    assign w_at_chk  = (r_edge == w_chk);
    assign w_at_last = (r_edge == w_last);

    // State and all registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_edge     <= '0;
            r_bit      <= '0;
            r_par_flag <= 1'b0;
            r_stp_flag <= 1'b0;
            r_en       <= '0;
            r_pulse    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_edge     <= w_edge_nxt;
            r_bit      <= w_bit_nxt;
            r_par_flag <= w_par_flag_nxt;
            r_stp_flag <= w_stp_flag_nxt;
            r_en       <= w_en_nxt;
            r_pulse    <= w_pulse_nxt;
        end
    end

    // Frame sequencing
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!i_rx_in) w_state_nxt = S_START;
            S_START: begin
                if (w_at_chk && dp.strt_glitch) w_state_nxt = S_IDLE;
                else if (w_at_last)             w_state_nxt = S_DATA;
            end
            S_DATA:   if (w_at_last && (r_bit == LAST_BIT))
                          w_state_nxt = i_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_at_last) w_state_nxt = S_STOP;
            S_STOP:   if (w_at_last) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Counters, error flags, enables and result pulses for the next cycle
    always_comb begin
        w_edge_nxt     = '0;
        w_bit_nxt      = '0;
        w_par_flag_nxt = r_par_flag;
        w_stp_flag_nxt = r_stp_flag;
        w_pulse_nxt    = '0;

        if ((r_state != S_IDLE) && (w_state_nxt != S_IDLE) && !w_at_last)
            w_edge_nxt = r_edge + PRESC_W'(1);
        if (w_state_nxt == r_state)
            w_bit_nxt = ((r_state == S_DATA) && w_at_last) ? r_bit + BIT_W'(1) : r_bit;

        if ((r_state == S_PARITY) && w_at_chk && dp.par_err) w_par_flag_nxt = 1'b1;
        if ((r_state == S_STOP) && w_at_chk && dp.stp_err)   w_stp_flag_nxt = 1'b1;

        if ((r_state == S_STOP) && (w_state_nxt == S_IDLE)) begin
            w_pulse_nxt    = {!w_par_flag_nxt && !w_stp_flag_nxt, w_par_flag_nxt, w_stp_flag_nxt};
            w_par_flag_nxt = 1'b0;
            w_stp_flag_nxt = 1'b0;
        end

        // Registered from next state so enables line up with the state they decode
        w_en_nxt = {w_state_nxt != S_IDLE,
                    w_state_nxt == S_DATA,
                    w_state_nxt == S_START,
                    w_state_nxt == S_PARITY,
                    w_state_nxt == S_STOP};
    end

    assign dp.edge_count = r_edge;
    assign dp.bit_count  = r_bit;
    assign {dp.samp_en, dp.deser_en, dp.strt_chk_en, dp.par_chk_en, dp.stp_chk_en} = r_en;
    assign o_busy        = r_en[4];
    assign {o_data_valid, o_parity_error, o_framing_error} = r_pulse;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drives serial frames and checker responses,
// scoreboards the expected result pulse (kind and cycle) for each frame.
module tb_uart_rx_ctrl;
    typedef struct {
        int   cyc;
        logic dv;
        logic pe;
        logic fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx_in;
    logic       par_en;
    logic [5:0] prescale;
    logic       dv, pe, fe, busy;

    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   deser_cnt = 0;
    int   idle_from = 0;
    exp_t sb[$];
    exp_t mon_e;

    uart_rx_ctrl_if #(.PRESC_W(6)) dp_if ();

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_rx_in        (rx_in),
        .i_par_en       (par_en),
        .i_prescale     (prescale),
        .dp             (dp_if),
        .o_data_valid   (dv),
        .o_parity_error (pe),
        .o_framing_error(fe),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse monitor: every pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rstn) begin
            if (dp_if.deser_en) deser_cnt++;
            if (dv || pe || fe) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {29'd0, dv, pe, fe}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("pulse_kind", {29'd0, dv, pe, fe}, {29'd0, mon_e.dv, mon_e.pe, mon_e.fe});
                    check("busy_at_pulse", 32'(busy), 32'd0);
                end
            end
        end
    end

    // Drives one frame on the line; checker errors are held for the whole frame
    task automatic send_frame(input int p, input logic par, input logic [7:0] d,
                              input logic perr, input logic serr);
        logic [10:0] line;
        int          nbits;
        int          s;
        logic        fresh;
        exp_t        e;
        prescale      = 6'(p);
        par_en        = par;
        dp_if.par_err = perr;
        dp_if.stp_err = serr;
        nbits = par ? 11 : 10;
        line  = {1'b1, (par ? ^d : 1'b1), d, 1'b0};
        fresh = (cyc + 1 > idle_from + 1);
        s     = fresh ? cyc + 1 : idle_from + 1;
        e.cyc = s + nbits * p;
        e.pe  = perr & par;
        e.fe  = serr;
        e.dv  = !(e.pe || e.fe);
        idle_from = e.cyc;
        sb.push_back(e);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < p; c++) begin
                rx_in = line[b];
                tick(1);
                if (fresh && b == 0 && c == 0) begin
                    check("start_busy", 32'(busy), 32'd1);
                    check("start_edge0", 32'(dp_if.edge_count), 32'd0);
                end
            end
        end
        rx_in = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        check("pulse_arrived", 32'(sb.size()), 32'd0);
        tick(2);
    endtask

    initial begin
        rstn              = 1'b0;
        rx_in             = 1'b1;
        par_en            = 1'b0;
        prescale          = 6'd8;
        dp_if.strt_glitch = 1'b0;
        dp_if.par_err     = 1'b0;
        dp_if.stp_err     = 1'b0;
        tick(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_edge", 32'(dp_if.edge_count), 32'd0);
        check("rst_bit", 32'(dp_if.bit_count), 32'd0);
        check("rst_en", {27'd0, dp_if.samp_en, dp_if.deser_en, dp_if.strt_chk_en,
                         dp_if.par_chk_en, dp_if.stp_chk_en}, 32'd0);
        check("rst_pulses", {29'd0, dv, pe, fe}, 32'd0);
        rstn = 1'b1;
        tick(3);
        check("idle_busy", 32'(busy), 32'd0);

        // Clean frame, no parity: deser_en spans exactly 8 data bits
        deser_cnt = 0;
        send_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0);
        wait_drain(200);
        check("deser_cycles", 32'(deser_cnt), 32'd64);

        // Start glitch aborts the frame at edge CHK
        deser_cnt = 0;
        prescale = 6'd8;
        dp_if.strt_glitch = 1'b1;
        rx_in = 1'b0;
        tick(1);
        check("glitch_start_en", 32'(dp_if.strt_chk_en), 32'd1);
        tick(2);
        rx_in = 1'b1;
        tick(4);
        check("glitch_edge6_busy", 32'(busy), 32'd1);
        check("glitch_edge6", 32'(dp_if.edge_count), 32'd6);
        tick(1);
        check("glitch_idle", 32'(busy), 32'd0);
        check("glitch_edge_clr", 32'(dp_if.edge_count), 32'd0);
        dp_if.strt_glitch = 1'b0;
        tick(20);
        check("glitch_no_deser", 32'(deser_cnt), 32'd0);

        // Parity error, prescale 16
        send_frame(16, 1'b1, 8'h3C, 1'b1, 1'b0);
        wait_drain(400);
        // Framing error
        send_frame(8, 1'b0, 8'h5A, 1'b0, 1'b1);
        wait_drain(200);
        // par_err ignored when the frame has no parity bit
        send_frame(8, 1'b0, 8'hC3, 1'b1, 1'b0);
        wait_drain(200);
        // Both errors together
        send_frame(8, 1'b1, 8'h81, 1'b1, 1'b1);
        wait_drain(200);

        // Reset mid-DATA aborts silently
        prescale = 6'd8;
        par_en   = 1'b0;
        dp_if.par_err = 1'b0;
        dp_if.stp_err = 1'b0;
        rx_in = 1'b0;
        tick(1);
        tick(7);
        rx_in = 1'b1;
        tick(25);
        check("data_bit3", 32'(dp_if.bit_count), 32'd3);
        check("data_deser", 32'(dp_if.deser_en), 32'd1);
        rstn = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_edge", 32'(dp_if.edge_count), 32'd0);
        check("abort_bit", 32'(dp_if.bit_count), 32'd0);
        check("abort_en", {27'd0, dp_if.samp_en, dp_if.deser_en, dp_if.strt_chk_en,
                           dp_if.par_chk_en, dp_if.stp_chk_en}, 32'd0);
        tick(3);
        check("abort_hold", {28'd0, busy, dv, pe, fe}, 32'd0);
        rstn = 1'b1;
        idle_from = 0;
        tick(2);
        send_frame(8, 1'b0, 8'h96, 1'b0, 1'b0);
        wait_drain(200);

        // Back-to-back frames at prescale 32
        send_frame(32, 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(32, 1'b0, 8'hFF, 1'b0, 1'b0);
        wait_drain(800);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
